// File: rtl/out_drain_sched_if.sv
// Column-side pop bus plus downstream result stream of the drain scheduler.
interface out_drain_sched_if #(
  parameter int NCOL = 8,
  parameter int DW   = 32
);
  localparam int CIW = (NCOL > 1) ? $clog2(NCOL) : 1;

  logic [NCOL-1:0]    col_v;
  logic [NCOL*DW-1:0] col_d;
  logic [NCOL-1:0]    col_rd;
  logic               m_valid;
  logic [DW-1:0]      m_data;
  logic [CIW-1:0]     m_col;
  logic               m_last;
  logic               m_ready;

  modport master (
    input  col_v, col_d, m_ready,
    output col_rd, m_valid, m_data, m_col, m_last
  );

  modport slave (
    output col_v, col_d, m_ready,
    input  col_rd, m_valid, m_data, m_col, m_last
  );
endinterface

// File: rtl/out_drain_sched.sv
// Round-robin drain of NCOL column controllers into one tagged result stream,
// popping exactly cfg_words words per tile and marking the last one.
module out_drain_sched #(
  parameter int NCOL = 8,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [CW-1:0] cfg_words,
  output logic          busy,
  output logic          done,
  out_drain_sched_if.master bus
);
  localparam int CIW = (NCOL > 1) ? $clog2(NCOL) : 1;

  // state | meaning
  // IDLE  | waiting for start, no pops
  // RUN   | granting columns while words remain and the output slot is free
  // LAST  | final word held in the output slot until accepted
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_rem;
  logic [CIW-1:0]  r_rr;
  logic            r_valid;
  logic [DW-1:0]   r_data;
  logic [CIW-1:0]  r_col;
  logic            r_last;
  logic            r_done;

  logic            w_slot_free;
  logic            w_found;
  logic [CIW-1:0]  w_gnt;
  logic [CIW-1:0]  w_rr_nxt;
  logic            w_grant;
  logic [NCOL-1:0] w_col_rd;
  logic [DW-1:0]   w_gnt_data;

  assign w_slot_free = !r_valid || bus.m_ready;

  // Rotating priority search starting at the column after the last grant.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_gnt   = '0;
    idx     = 0;
    for (int i = 0; i < NCOL; i++) begin
      idx = (int'(r_rr) + i) % NCOL;
      if (!w_found && bus.col_v[idx]) begin
        w_found = 1'b1;
        w_gnt   = idx[CIW-1:0];
      end
    end
  end

  assign w_grant    = (r_state == S_RUN) && w_slot_free && (r_rem != '0) && w_found;
  assign w_rr_nxt   = (w_gnt == CIW'(NCOL-1)) ? '0 : w_gnt + 1'b1;
  assign w_gnt_data = bus.col_d[int'(w_gnt)*DW +: DW];

  always_comb begin
    w_col_rd = '0;
    if (w_grant) w_col_rd[w_gnt] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start && (cfg_words != '0)) w_state_nxt = S_RUN;
      S_RUN:  if (w_grant && (r_rem == CW'(1))) w_state_nxt = S_LAST;
      S_LAST: if (r_valid && bus.m_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_rr    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_col   <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_rem  <= cfg_words;
          r_rr   <= '0;
          r_done <= (cfg_words == '0);
        end
        S_LAST: if (r_valid && bus.m_ready) r_done <= 1'b1;
        default: ;
      endcase
      // Accept and re-fill share one edge, giving back-to-back words.
      if (w_grant) begin
        r_valid <= 1'b1;
        r_data  <= w_gnt_data;
        r_col   <= w_gnt;
        r_last  <= (r_rem == CW'(1));
        r_rem   <= r_rem - 1'b1;
        r_rr    <= w_rr_nxt;
      end else if (r_valid && bus.m_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign bus.col_rd  = w_col_rd;
  assign bus.m_valid = r_valid;
  assign bus.m_data  = r_data;
  assign bus.m_col   = r_col;
  assign bus.m_last  = r_last;
endmodule

// File: tb/tb_out_drain_sched.sv
// Bench for out_drain_sched: fixed vector table, directed corner sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_out_drain_sched;
  localparam int NCOL = 8;
  localparam int DW   = 32;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_words = '0;
  logic          busy, done;

  out_drain_sched_if #(.NCOL(NCOL), .DW(DW)) bus ();

  out_drain_sched #(.NCOL(NCOL), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_words(cfg_words),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: an output slot holding at most one word, a word budget
  // and a round-robin pointer; grants follow the fairness rule directly.
  bit            mdl_busy;
  int            mdl_rem, mdl_rr;
  bit            mdl_has;
  logic [DW-1:0] mdl_wd;
  int            mdl_wc;
  bit            mdl_wl;
  bit            mdl_done;
  bit            done_seen;
  int            got_q[$];
  int            exp_q[$];

  task automatic model_reset();
    mdl_busy = 0; mdl_rem = 0; mdl_rr = 0; mdl_has = 0;
    mdl_wd = '0; mdl_wc = 0; mdl_wl = 0; mdl_done = 0;
  endtask

  task automatic step();
    int pick;
    bit slot, was_busy, nd;
    logic [NCOL-1:0] exp_rd;
    was_busy = mdl_busy;
    slot = !mdl_has || bus.m_ready;
    pick = -1;
    if (mdl_busy && slot && mdl_rem > 0)
      for (int s = 0; s < NCOL; s++) begin
        int c;
        c = (mdl_rr + s) % NCOL;
        if (pick < 0 && bus.col_v[c]) pick = c;
      end
    exp_rd = '0;
    if (pick >= 0) exp_rd[pick] = 1'b1;
    chk("col_rd", bus.col_rd, exp_rd);
    chk("busy", busy, mdl_busy);
    chk("done", done, mdl_done);
    chk("m_valid", bus.m_valid, mdl_has);
    if (mdl_has) begin
      chk("m_data", bus.m_data, mdl_wd);
      chk("m_col", bus.m_col, mdl_wc);
      chk("m_last", bus.m_last, mdl_wl);
    end
    if (done) done_seen = 1;
    nd = 0;
    if (mdl_has && bus.m_ready) begin
      got_q.push_back(mdl_wc);
      mdl_has = 0;
      if (mdl_wl) begin nd = 1; mdl_busy = 0; end
    end
    if (pick >= 0) begin
      mdl_has = 1;
      mdl_wd  = bus.col_d[pick*DW +: DW];
      mdl_wc  = pick;
      mdl_wl  = (mdl_rem == 1);
      mdl_rem = mdl_rem - 1;
      mdl_rr  = (pick + 1) % NCOL;
    end
    if (!was_busy && start) begin
      if (cfg_words == 0) nd = 1;
      else begin mdl_busy = 1; mdl_rem = cfg_words; mdl_rr = 0; end
    end
    mdl_done = nd;
  endtask

  task automatic cycle();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cd(bit rnd);
    for (int k = 0; k < NCOL; k++)
      bus.col_d[k*DW +: DW] = rnd ? DW'($urandom) : 32'hC000_0000 + DW'(k);
  endtask

  task automatic run_until_done(int budget, int mode, string nm);
    done_seen = 0;
    for (int k = 0; k < budget && !done_seen; k++) begin
      if (mode == 1) bus.col_v = (k % 4 == 0) ? 8'h20 : 8'h00;
      if (mode == 2) begin
        bus.col_v   = NCOL'($urandom);
        bus.m_ready = ($urandom_range(0, 3) != 0);
        start       = ($urandom_range(0, 5) == 0);
        cfg_words   = CW'($urandom_range(0, 10));
        drive_cd(1);
      end
      cycle();
    end
    chk({nm, "_done_seen"}, done_seen, 1);
  endtask

  task automatic check_seq(string nm);
    chk({nm, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({nm, "_col"}, got_q[i], exp_q[i]);
  endtask

  typedef struct {
    bit            st;
    logic [CW-1:0] cfg;
    logic [7:0]    cv;
    bit            rdy;
    logic [7:0]    e_rd;
    bit            e_v;
    logic [2:0]    e_col;
    bit            e_last;
    bit            e_done;
    bit            e_busy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 8, 8'hFF, 1, 8'h00, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 8'hFF, 1, 8'h01, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 8'hFF, 1, 8'h02, 1, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 8'hFF, 1, 8'h04, 1, 1, 0, 0, 1};
    tbl[4]  = '{0, 0, 8'hFF, 1, 8'h08, 1, 2, 0, 0, 1};
    tbl[5]  = '{0, 0, 8'hFF, 1, 8'h10, 1, 3, 0, 0, 1};
    tbl[6]  = '{0, 0, 8'hFF, 1, 8'h20, 1, 4, 0, 0, 1};
    tbl[7]  = '{0, 0, 8'hFF, 1, 8'h40, 1, 5, 0, 0, 1};
    tbl[8]  = '{0, 0, 8'hFF, 1, 8'h80, 1, 6, 0, 0, 1};
    tbl[9]  = '{0, 0, 8'hFF, 1, 8'h00, 1, 7, 1, 0, 1};
    tbl[10] = '{0, 0, 8'hFF, 1, 8'h00, 0, 0, 0, 1, 0};
    tbl[11] = '{0, 0, 8'hFF, 1, 8'h00, 0, 0, 0, 0, 0};

    model_reset();
    bus.col_v = '0; bus.m_ready = 1'b0; drive_cd(0);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_col_rd", bus.col_rd, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_col", bus.m_col, 0);
    chk("rst_m_last", bus.m_last, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Basic full-rate tile from the vector table
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; cfg_words = tbl[i].cfg;
      bus.col_v = tbl[i].cv; bus.m_ready = tbl[i].rdy;
      @(negedge clk);
      chk("tbl_col_rd", bus.col_rd, tbl[i].e_rd);
      chk("tbl_m_valid", bus.m_valid, tbl[i].e_v);
      chk("tbl_done", done, tbl[i].e_done);
      chk("tbl_busy", busy, tbl[i].e_busy);
      if (tbl[i].e_v) begin
        chk("tbl_m_col", bus.m_col, tbl[i].e_col);
        chk("tbl_m_last", bus.m_last, tbl[i].e_last);
        chk("tbl_m_data", bus.m_data, 32'hC000_0000 + 32'(tbl[i].e_col));
      end
      step();
      @(posedge clk); #1;
    end

    // Fairness with wrap between columns 2 and 7
    got_q.delete();
    bus.col_v = 8'b1000_0100; bus.m_ready = 1'b1;
    start = 1'b1; cfg_words = 6; cycle(); start = 1'b0;
    run_until_done(40, 0, "fair");
    exp_q = '{2, 7, 2, 7, 2, 7};
    check_seq("fair");

    // Backpressure, with a start issued while busy that must be ignored
    got_q.delete();
    bus.col_v = 8'hFF; bus.m_ready = 1'b1;
    start = 1'b1; cfg_words = 8; cycle(); start = 1'b0;
    cycle();
    bus.m_ready = 1'b0; start = 1'b1; cfg_words = 3;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_m_data", bus.m_data, 32'hC000_0000);
      chk("bp_m_col", bus.m_col, 0);
      chk("bp_col_rd", bus.col_rd, 0);
    end
    start = 1'b0; bus.m_ready = 1'b1;
    run_until_done(60, 0, "bp");
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_seq("bp");

    // Sparse data from column 5 only
    got_q.delete();
    bus.col_v = '0;
    start = 1'b1; cfg_words = 3; cycle(); start = 1'b0;
    run_until_done(60, 1, "sparse");
    exp_q = '{5, 5, 5};
    check_seq("sparse");

    // Zero-length tile
    bus.col_v = 8'hFF;
    start = 1'b1; cfg_words = 0; cycle(); start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_col_rd", bus.col_rd, 0);
    cycle();
    chk("zero_done_clr", done, 0);

    // Asynchronous reset mid-tile, then restart searching from column 0
    got_q.delete();
    start = 1'b1; cfg_words = 8; cycle(); start = 1'b0;
    for (int k = 0; k < 50 && got_q.size() < 3; k++) cycle();
    chk("mid_words_before_rst", got_q.size(), 3);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_col_rd", bus.col_rd, 0);
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_m_data", bus.m_data, 0);
    chk("mid_rst_m_col", bus.m_col, 0);
    chk("mid_rst_m_last", bus.m_last, 0);
    model_reset();
    got_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.col_v = 8'h81;
    start = 1'b1; cfg_words = 2; cycle(); start = 1'b0;
    run_until_done(40, 0, "post_rst");
    exp_q = '{0, 7};
    check_seq("post_rst");

    // Randomized traffic against the model
    for (int t = 0; t < 30; t++) begin
      start = 1'b1; cfg_words = CW'($urandom_range(0, 10));
      cycle(); start = 1'b0;
      run_until_done(400, 2, "rand");
    end
    start = 1'b0; bus.m_ready = 1'b1; bus.col_v = 8'hFF;
    for (int k = 0; k < 60 && mdl_busy; k++) cycle();
    chk("rand_drained", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
